four_bit_sort_ctrl: RTL and testbench



---
 rtl/sort_pkg.sv | 11 +
 rtl/FourBitComp.sv | 12 +
 rtl/four_bit_sort_ctrl.sv | 113 +++++++++++
 tb/tb_four_bit_sort_ctrl.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/sort_pkg.sv
// Shared constants and state encoding for the sorting controller.
package sort_pkg;
  localparam int DATA_W = 4;
  localparam int SWAP_W = 6;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    SORT  = 2'd1,
    DRAIN = 2'd2
  } state_t;
endpackage

// File: rtl/FourBitComp.sv
// Unsigned 4-bit magnitude comparator: exactly one of l (a<b), e (a==b), m (a>b) is high.
module FourBitComp (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic       l,
  output logic       e,
  output logic       m
);
  assign l = (a < b);
  assign e = (a == b);
  assign m = (a > b);
endmodule

// File: rtl/four_bit_sort_ctrl.sv
// Block sorter: loads N values, bubble-sorts them with one shared comparator
// on a fixed (N-1)^2-cycle schedule, then streams them out ascending.
module four_bit_sort_ctrl
  import sort_pkg::*;
#(
  parameter int N = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic              busy,
  output logic [SWAP_W-1:0] swap_count
);
  localparam int IDX_W = $clog2(N);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);
  localparam logic [IDX_W-1:0] CMP_LAST = IDX_W'(N - 2);

  state_t state_reg, state_next;

  logic [DATA_W-1:0] sort_buf [N];
  logic [IDX_W-1:0]  wr_idx_reg, rd_idx_reg, idx_reg, pass_reg;
  logic [IDX_W-1:0]  idx_hi;
  logic [SWAP_W-1:0] swap_count_reg;

  logic [DATA_W-1:0] cmp_a, cmp_b;
  logic cmp_l, cmp_e, cmp_m;
  logic accept, xfer, do_swap;
  logic load_done, sort_done, drain_done;

  assign idx_hi = idx_reg + IDX_W'(1);
  assign cmp_a  = sort_buf[idx_reg];
  assign cmp_b  = sort_buf[idx_hi];

  FourBitComp u_comp (
    .a (cmp_a),
    .b (cmp_b),
    .l (cmp_l),
    .e (cmp_e),
    .m (cmp_m)
  );

  assign accept     = (state_reg == LOAD) && in_valid;
  assign xfer       = (state_reg == DRAIN) && out_ready;
  // Equal or smaller pairs never move, which keeps the sort stable.
  assign do_swap    = (state_reg == SORT) && cmp_m && !cmp_e && !cmp_l;
  assign load_done  = accept && (wr_idx_reg == LAST_IDX);
  assign sort_done  = (state_reg == SORT) && (idx_reg == CMP_LAST) && (pass_reg == CMP_LAST);
  assign drain_done = xfer && (rd_idx_reg == LAST_IDX);

  always_ff @(posedge clk) begin
    if (rst) state_reg <= LOAD;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      LOAD:    if (load_done)  state_next = SORT;
      SORT:    if (sort_done)  state_next = DRAIN;
      DRAIN:   if (drain_done) state_next = LOAD;
      default: state_next = LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_idx_reg     <= '0;
      rd_idx_reg     <= '0;
      idx_reg        <= '0;
      pass_reg       <= '0;
      swap_count_reg <= '0;
    end else begin
      if (accept) wr_idx_reg <= load_done ? '0 : wr_idx_reg + IDX_W'(1);
      if (xfer)   rd_idx_reg <= drain_done ? '0 : rd_idx_reg + IDX_W'(1);
      if (load_done) begin
        idx_reg        <= '0;
        pass_reg       <= '0;
        swap_count_reg <= '0;
      end else if (state_reg == SORT) begin
        if (do_swap) swap_count_reg <= swap_count_reg + SWAP_W'(1);
        if (idx_reg == CMP_LAST) begin
          idx_reg  <= '0;
          pass_reg <= sort_done ? '0 : pass_reg + IDX_W'(1);
        end else begin
          idx_reg <= idx_hi;
        end
      end
    end
  end

  // Each entry has its own write port: load, or either side of a swap.
  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_entry
      always_ff @(posedge clk) begin
        if (rst)                                          sort_buf[gi] <= '0;
        else if (accept && wr_idx_reg == IDX_W'(gi))      sort_buf[gi] <= in_data;
        else if (do_swap && idx_reg == IDX_W'(gi))        sort_buf[gi] <= cmp_b;
        else if (do_swap && idx_hi == IDX_W'(gi))         sort_buf[gi] <= cmp_a;
      end
    end
  endgenerate

  assign in_ready   = (state_reg == LOAD);
  assign out_valid  = (state_reg == DRAIN);
  assign busy       = (state_reg == SORT) || (state_reg == DRAIN);
  assign out_data   = (state_reg == DRAIN) ? sort_buf[rd_idx_reg] : '0;
  assign swap_count = swap_count_reg;
endmodule

// File: tb/tb_four_bit_sort_ctrl.sv
// Bench for four_bit_sort_ctrl at N=4: directed vector table, reset abort, and random blocks vs. a model.
module tb_four_bit_sort_ctrl;
  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [3:0] in_data;
  logic       in_ready;
  logic       out_valid;
  logic [3:0] out_data;
  logic       out_ready;
  logic       busy;
  logic [5:0] swap_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  four_bit_sort_ctrl #(.N(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_ready  (out_ready),
    .busy       (busy),
    .swap_count (swap_count)
  );

  typedef struct {
    logic [3:0] din [4];
    logic [3:0] dout [4];
    int         swaps;
    bit         hold_valid;
    bit         bp;
  } vec_t;

  vec_t vecs [5];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_in_ready"}, int'(in_ready), 1);
    chk({tag, "_out_valid"}, int'(out_valid), 0);
    chk({tag, "_out_data"}, int'(out_data), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_swap_count"}, int'(swap_count), 0);
  endtask

  // Reference: ascending order by counting values, swaps = number of inversions.
  task automatic model(input logic [3:0] din [4], output logic [3:0] dout [4], output int swaps);
    int k;
    k = 0;
    for (int v = 0; v < 16; v++)
      for (int i = 0; i < 4; i++)
        if (int'(din[i]) == v) begin
          dout[k] = 4'(v);
          k++;
        end
    swaps = 0;
    for (int i = 0; i < 4; i++)
      for (int j = i + 1; j < 4; j++)
        if (din[i] > din[j]) swaps++;
  endtask

  task automatic load_values(input logic [3:0] din [4], input bit hold_valid);
    for (int i = 0; i < 4; i++) begin
      chk("in_ready_load", int'(in_ready), 1);
      in_valid = 1'b1;
      in_data  = din[i];
      @(negedge clk);
    end
    in_valid = hold_valid;
    in_data  = 4'hF;
  endtask

  task automatic run_block(input string tag, input logic [3:0] din [4], input logic [3:0] dout [4],
                           input int swaps, input bit hold_valid, input bit bp);
    int cyc;
    load_values(din, hold_valid);
    cyc = 0;
    while (busy && !out_valid && cyc < 40) begin
      chk("in_ready_sort", int'(in_ready), 0);
      cyc++;
      @(negedge clk);
    end
    chk("sort_cycles", cyc, 9);
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("out_valid", int'(out_valid), 1);
      chk("out_data", int'(out_data), int'(dout[i]));
      if (i == 0 && bp) begin
        out_ready = 1'b0;
        repeat (3) begin
          @(negedge clk);
          chk("stall_valid", int'(out_valid), 1);
          chk("stall_data", int'(out_data), int'(dout[0]));
        end
        out_ready = 1'b1;
      end
      @(negedge clk);
    end
    chk("post_out_valid", int'(out_valid), 0);
    chk("post_in_ready", int'(in_ready), 1);
    chk("post_busy", int'(busy), 0);
    chk("swap_count", int'(swap_count), swaps);
    $display("block %s: in=%0d,%0d,%0d,%0d swaps=%0d (expected %0d)", tag,
             din[0], din[1], din[2], din[3], swap_count, swaps);
  endtask

  initial begin
    logic [3:0] rin [4];
    logic [3:0] rout [4];
    int rswaps;

    vecs[0].din = '{4'd12, 4'd3, 4'd6, 4'd2};    vecs[0].dout = '{4'd2, 4'd3, 4'd6, 4'd12};
    vecs[0].swaps = 5; vecs[0].hold_valid = 0; vecs[0].bp = 0;
    vecs[1].din = '{4'd0, 4'd1, 4'd2, 4'd3};     vecs[1].dout = '{4'd0, 4'd1, 4'd2, 4'd3};
    vecs[1].swaps = 0; vecs[1].hold_valid = 0; vecs[1].bp = 0;
    vecs[2].din = '{4'd15, 4'd14, 4'd13, 4'd12}; vecs[2].dout = '{4'd12, 4'd13, 4'd14, 4'd15};
    vecs[2].swaps = 6; vecs[2].hold_valid = 0; vecs[2].bp = 0;
    vecs[3].din = '{4'd5, 4'd5, 4'd5, 4'd0};     vecs[3].dout = '{4'd0, 4'd5, 4'd5, 4'd5};
    vecs[3].swaps = 3; vecs[3].hold_valid = 1; vecs[3].bp = 0;
    vecs[4].din = '{4'd12, 4'd3, 4'd6, 4'd2};    vecs[4].dout = '{4'd2, 4'd3, 4'd6, 4'd12};
    vecs[4].swaps = 5; vecs[4].hold_valid = 0; vecs[4].bp = 1;

    rst = 1'b1; in_valid = 1'b0; in_data = 4'd0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk_idle("reset");
    rst = 1'b0;
    @(negedge clk);
    chk_idle("after_reset");

    for (int v = 0; v < 5; v++) run_block($sformatf("vec%0d", v), vecs[v].din, vecs[v].dout,
                                          vecs[v].swaps, vecs[v].hold_valid, vecs[v].bp);

    // Abort a block on SORT cycle 4, then check the next block carries no residue.
    rin = '{4'd9, 4'd8, 4'd7, 4'd6};
    load_values(rin, 1'b0);
    chk("abort_in_sort", int'(busy), 1);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_idle("abort");
    rin  = '{4'd1, 4'd0, 4'd0, 4'd0};
    rout = '{4'd0, 4'd0, 4'd0, 4'd1};
    run_block("after_abort", rin, rout, 3, 1'b0, 1'b0);

    for (int r = 0; r < 20; r++) begin
      for (int i = 0; i < 4; i++) rin[i] = 4'($urandom_range(0, 15));
      model(rin, rout, rswaps);
      run_block($sformatf("rand%0d", r), rin, rout, rswaps, 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
